pio_output_pulse: RTL and testbench
===================================

PIO_OUTPUT_PULSE -- requirements
Module: pio_output_pulse

Interface
REQ-001 Parameter WIDTH, default 16, number of output bits (legal 1..32).
REQ-002 Parameter LEN_W, default 16, pulse-length counter width (legal 1..32).
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit power-up value of out_port.
REQ-004 Parameter PULSE_DEFAULT, default 1000, reset value of PULSE_LEN (must fit LEN_W).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; write when chipselect=1 and write_n=0.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, combinational, zero wait states.
REQ-012 out_port  output  WIDTH  registered output pins.
REQ-013 irq  output  1  level interrupt = DONE & IRQ_EN.

Function
REQ-014 Register map SHALL be: 0 DATA RW; 1 STATUS; 2 PULSE_LEN RW; 3 PULSE_TRIG (W: trigger, R: pulse mask); 4 SET WO; 5 CLR WO; 6 TOG WO; 7 COUNT RO.
REQ-015 DATA write: out <= writedata[WIDTH-1:0]; mask <= 0; DONE unaffected.
REQ-016 SET write: out <= out | wd; CLR: out <= out & ~wd, mask <= mask & ~wd; TOG: out <= out ^ wd, mask <= mask & ~wd.
REQ-017 PULSE_TRIG write with PULSE_LEN != 0: out <= out | wd; mask <= mask | wd; count <= PULSE_LEN; busy from the next cycle.
REQ-018 PULSE_TRIG write with PULSE_LEN = 0 or wd[WIDTH-1:0] = 0: no effect.
REQ-019 While count != 0, count SHALL decrement by 1 per cycle; bits are high for exactly PULSE_LEN cycles after the trigger edge.
REQ-020 Expiry (count = 1 and decrementing): next edge out <= out & ~mask, mask <= 0, count <= 0, DONE <= 1.
REQ-021 Retrigger during an active pulse SHALL OR new bits into mask and reload count; if coincident with expiry, retrigger wins (no bits cleared, DONE not set).
REQ-022 DATA/SET/CLR/TOG write coincident with expiry: expiry clear applied first, then the write; written value wins per bit.
REQ-023 mask bits cleared to 0 by writes leave count running; if mask becomes 0, count still expires and sets DONE.
REQ-024 STATUS read: bit0 BUSY (count != 0), bit1 DONE, bit8 IRQ_EN, others 0.
REQ-025 STATUS write: writedata[1]=1 clears DONE (expiry in same cycle wins, DONE stays 1); IRQ_EN <= writedata[8].
REQ-026 PULSE_LEN write takes writedata[LEN_W-1:0]; does not affect a running count.
REQ-027 Reads: DATA -> out, PULSE_LEN -> length, addr 3 -> mask, COUNT -> count, addrs 4-6 -> 0; all zero-extended to 32 bits.
REQ-028 writedata bits above WIDTH (or LEN_W) SHALL be ignored; no read side effects.
REQ-029 Writes with chipselect=0 or write_n=1 SHALL have no effect.

Reset
REQ-030 On reset_n=0, immediately: out=RESET_VALUE, mask=0, count=0, PULSE_LEN=PULSE_DEFAULT, DONE=0, IRQ_EN=0, irq=0.
REQ-031 Reset mid-pulse SHALL abort the pulse with no DONE; first post-reset edge behaves per REQ-030 values.

Verification
REQ-032 Write SET 0x0005, CLR 0x0004, TOG 0x0003 -> DATA reads 0x0002; out_port = 0x0002.
REQ-033 PULSE_LEN=3, TRIG 0x0010 -> out_port bit4 high exactly 3 cycles, COUNT reads 3,2,1,0, DONE=1; irq=1 only if IRQ_EN=1.
REQ-034 PULSE_LEN=4, TRIG 0x1, retrigger 0x2 on expiry cycle -> both bits high 4 more cycles, then both clear, single DONE.
REQ-035 PULSE_LEN=5, TRIG 0x3, CLR 0x1 mid-pulse -> bit0 low immediately, bit1 clears at expiry; SET 0x2 on expiry cycle -> bit1 stays 1.
REQ-036 PULSE_LEN=0, TRIG 0xFF -> out_port, mask, COUNT unchanged; then W1C DONE on expiry cycle -> DONE remains 1.
REQ-037 Assert reset_n=0 mid-pulse -> out_port=RESET_VALUE asynchronously, COUNT=0, PULSE_LEN=PULSE_DEFAULT, irq=0.

Source files
------------

// File: rtl/pio_output_pulse_if.sv
// ----------------------------------------------------------------------------
// pio_output_pulse_if
// Avalon-MM slave bus bundle for the pulse-capable PIO output block.
//   address    [2:0]  word address (master -> slave)
//   chipselect        slave select (master -> slave)
//   write_n           active-low write strobe (master -> slave)
//   writedata  [31:0] write data (master -> slave)
//   readdata   [31:0] combinational read data (slave -> master)
// ----------------------------------------------------------------------------
interface pio_output_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_output_pulse.sv
// ----------------------------------------------------------------------------
// pio_output_pulse
// Memory-mapped output port with set/clear/toggle access and a one-shot pulse
// engine: a trigger write raises selected bits, which fall again after a
// programmable number of clock cycles, then latches DONE (optionally as irq).
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port  registered output pins, WIDTH bits
//   irq       level interrupt, DONE & IRQ_EN
//
// Register map (word address)
//   0 DATA  RW   1 STATUS   2 PULSE_LEN RW   3 PULSE_TRIG (W trigger, R mask)
//   4 SET   WO   5 CLR WO   6 TOG WO         7 COUNT RO
// ----------------------------------------------------------------------------
module pio_output_pulse #(
    parameter int unsigned            WIDTH         = 16,
    parameter int unsigned            LEN_W         = 16,
    parameter logic [WIDTH-1:0]       RESET_VALUE   = '0,
    parameter int unsigned            PULSE_DEFAULT = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_output_pulse_if.slave    bus,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_TRIG   = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;
    localparam logic [2:0] A_TOG    = 3'd6;
    localparam logic [2:0] A_COUNT  = 3'd7;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_mask;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;
    logic             r_done;
    logic             r_irq_en;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic             w_trig;
    logic             w_expire;
    logic [WIDTH-1:0] w_out_next;
    logic [WIDTH-1:0] w_mask_next;
    logic [LEN_W-1:0] w_count_next;
    logic             w_done_next;
    logic [31:0]      w_rdata;
    logic             w_unused_wd;

    assign w_wr = bus.chipselect & ~bus.write_n;
    assign w_wd = bus.writedata[WIDTH-1:0];

    // Only part of the write bus is meaningful for a given WIDTH/LEN_W.
    assign w_unused_wd = ^bus.writedata;

    // A trigger with zero length or no selected bits is a no-op.
    assign w_trig   = w_wr && (bus.address == A_TRIG) && (r_len != '0) && (w_wd != '0);

    // Expiry is suppressed when a retrigger lands on the same edge: the
    // reload keeps every pulsed bit high and DONE stays untouched.
    assign w_expire = (r_count == LEN_W'(1)) && !w_trig;

    always_comb begin
        w_out_next   = r_out;
        w_mask_next  = r_mask;
        w_count_next = (r_count != '0) ? (r_count - LEN_W'(1)) : r_count;
        w_done_next  = r_done;

        // Expiry clear goes first so a coincident port write wins per bit.
        if (w_expire) begin
            w_out_next  = r_out & ~r_mask;
            w_mask_next = '0;
            w_done_next = 1'b1;
        end

        if (w_wr) begin
            case (bus.address)
                A_DATA: begin
                    w_out_next  = w_wd;
                    w_mask_next = '0;
                end
                A_STATUS: begin
                    // A DONE set by expiry on this edge beats the W1C.
                    if (bus.writedata[1] && !w_expire) begin
                        w_done_next = 1'b0;
                    end
                end
                A_TRIG: begin
                    if (w_trig) begin
                        w_out_next   = r_out | w_wd;
                        w_mask_next  = r_mask | w_wd;
                        w_count_next = r_len;
                    end
                end
                A_SET: begin
                    w_out_next = w_out_next | w_wd;
                end
                A_CLR: begin
                    w_out_next  = w_out_next & ~w_wd;
                    w_mask_next = w_mask_next & ~w_wd;
                end
                A_TOG: begin
                    w_out_next  = w_out_next ^ w_wd;
                    w_mask_next = w_mask_next & ~w_wd;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out    <= RESET_VALUE;
            r_mask   <= '0;
            r_count  <= '0;
            r_len    <= LEN_W'(PULSE_DEFAULT);
            r_done   <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_mask  <= w_mask_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
            if (w_wr && (bus.address == A_STATUS)) begin
                r_irq_en <= bus.writedata[8];
            end
            if (w_wr && (bus.address == A_LEN)) begin
                r_len <= bus.writedata[LEN_W-1:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            A_DATA:   w_rdata = 32'(r_out);
            A_STATUS: begin
                w_rdata[0] = (r_count != '0);
                w_rdata[1] = r_done;
                w_rdata[8] = r_irq_en;
            end
            A_LEN:    w_rdata = 32'(r_len);
            A_TRIG:   w_rdata = 32'(r_mask);
            A_COUNT:  w_rdata = 32'(r_count);
            default:  w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;
    assign out_port     = r_out;
    assign irq          = r_done & r_irq_en;

endmodule

// File: tb/tb_pio_output_pulse.sv
// ----------------------------------------------------------------------------
// tb_pio_output_pulse
// Directed bench for pio_output_pulse. A reference model tracks pulses as an
// absolute deadline (edge number) rather than a down-counter; a compare
// process checks out_port, irq and readdata against it after every edge, and
// directed sequences pin literal expectations.
// ----------------------------------------------------------------------------
module tb_pio_output_pulse;

    localparam int unsigned      W  = 16;
    localparam int unsigned      LW = 16;
    localparam logic [W-1:0]     RV = 16'h00A5;
    localparam int unsigned      PD = 1000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  out_port;
    logic          irq;

    int checks = 0;
    int errors = 0;

    pio_output_pulse_if bus_if();

    pio_output_pulse #(
        .WIDTH         (W),
        .LEN_W         (LW),
        .RESET_VALUE   (RV),
        .PULSE_DEFAULT (PD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0]  out;
        logic [W-1:0]  mask;
        logic [LW-1:0] len;
        bit            done;
        bit            irq_en;
        bit            active;
        longint        edge_n;
        longint        deadline;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t s;
        s.out = RV; s.mask = '0; s.len = LW'(PD);
        s.done = 1'b0; s.irq_en = 1'b0; s.active = 1'b0;
        s.edge_n = 0; s.deadline = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit wr, logic [2:0] a, logic [31:0] d);
        mstate_t n = s;
        logic [W-1:0] wd = d[W-1:0];
        bit fin, trig, clear;
        n.edge_n = s.edge_n + 1;
        fin   = s.active && (n.edge_n == s.deadline);
        trig  = wr && (a == 3'd3) && (s.len != '0) && (wd != '0);
        clear = fin && !trig;
        if (fin) n.active = 1'b0;
        if (clear) begin
            n.out  = s.out & ~s.mask;
            n.mask = '0;
            n.done = 1'b1;
        end
        if (wr) begin
            case (a)
                3'd0: begin n.out = wd; n.mask = '0; end
                3'd1: begin
                    if (d[1] && !clear) n.done = 1'b0;
                    n.irq_en = d[8];
                end
                3'd2: n.len = d[LW-1:0];
                3'd3: if (trig) begin
                    n.out      = s.out | wd;
                    n.mask     = s.mask | wd;
                    n.active   = 1'b1;
                    n.deadline = n.edge_n + longint'(s.len);
                end
                3'd4: n.out = n.out | wd;
                3'd5: begin n.out = n.out & ~wd; n.mask = n.mask & ~wd; end
                3'd6: begin n.out = n.out ^ wd; n.mask = n.mask & ~wd; end
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] mread(mstate_t s, logic [2:0] a);
        logic [31:0] r = '0;
        case (a)
            3'd0: r = 32'(s.out);
            3'd1: begin r[0] = s.active; r[1] = s.done; r[8] = s.irq_en; end
            3'd2: r = 32'(s.len);
            3'd3: r = 32'(s.mask);
            3'd7: r = s.active ? 32'(s.deadline - s.edge_n) : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= mreset();
        else m <= mstep(m, bus_if.chipselect & ~bus_if.write_n,
                        bus_if.address, bus_if.writedata);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #3;
        check("cyc_out_port", 32'(out_port), 32'(m.out));
        check("cyc_irq", 32'(irq), 32'(m.done & m.irq_en));
        check("cyc_readdata", bus_if.readdata, mread(m, bus_if.address));
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        $display("WR addr=%0d data=0x%08h t=%0t", a, d, $time);
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        #1;
        $display("RD addr=%0d data=0x%08h t=%0t", a, bus_if.readdata, $time);
        check(name, bus_if.readdata, exp);
    endtask

    task automatic chk_out(input string name, input logic [31:0] exp);
        check(name, 32'(out_port), exp);
    endtask

    initial begin
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        reset_n           = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_out("rst_out", 32'h00A5);
        check("rst_irq", 32'(irq), 32'd0);
        chk_rd("rst_len", 3'd2, 32'd1000);
        chk_rd("rst_count", 3'd7, 32'd0);
        chk_rd("rst_status", 3'd1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // SET/CLR/TOG; upper writedata bits ignored
        wr(3'd0, 32'h0000_0000);
        wr(3'd4, 32'hFFFF_0005);
        wr(3'd5, 32'h0000_0004);
        wr(3'd6, 32'h0000_0003);
        chk_rd("sct_data", 3'd0, 32'h0000_0002);
        chk_out("sct_out", 32'h0002);

        // Single pulse, length 3, with IRQ enabled
        wr(3'd2, 32'd3);
        wr(3'd1, 32'h0000_0100);
        wr(3'd3, 32'h0000_0010);
        for (int k = 3; k >= 1; k--) begin
            chk_out("p3_out_high", 32'h0012);
            chk_rd("p3_count", 3'd7, 32'(k));
            idle(1);
        end
        chk_rd("p3_count_end", 3'd7, 32'd0);
        chk_out("p3_out_low", 32'h0002);
        chk_rd("p3_status", 3'd1, 32'h0000_0102);
        check("p3_irq", 32'(irq), 32'd1);
        wr(3'd1, 32'h0000_0002);
        chk_rd("p3_status_clr", 3'd1, 32'h0000_0000);
        check("p3_irq_off", 32'(irq), 32'd0);

        // Retrigger coincident with expiry
        wr(3'd2, 32'd4);
        wr(3'd3, 32'h0000_0001);
        idle(3);
        wr(3'd3, 32'h0000_0002);
        chk_out("rt_out", 32'h0003);
        chk_rd("rt_count", 3'd7, 32'd4);
        chk_rd("rt_status", 3'd1, 32'h0000_0001);
        idle(3);
        chk_out("rt_out_hold", 32'h0003);
        idle(1);
        chk_out("rt_out_clear", 32'h0000);
        chk_rd("rt_status_done", 3'd1, 32'h0000_0002);
        check("rt_irq_masked", 32'(irq), 32'd0);
        wr(3'd1, 32'h0000_0002);

        // CLR mid-pulse, SET on expiry edge
        wr(3'd2, 32'd5);
        wr(3'd3, 32'h0000_0003);
        idle(1);
        wr(3'd5, 32'h0000_0001);
        chk_out("cm_out_bit0_low", 32'h0002);
        chk_rd("cm_mask", 3'd3, 32'h0000_0002);
        idle(2);
        wr(3'd4, 32'h0000_0002);
        chk_out("cm_out_bit1_kept", 32'h0002);
        chk_rd("cm_mask_end", 3'd3, 32'h0000_0000);
        chk_rd("cm_status", 3'd1, 32'h0000_0002);
        wr(3'd1, 32'h0000_0002);

        // Null triggers and masked-off writes
        wr(3'd2, 32'd0);
        wr(3'd3, 32'h0000_00FF);
        chk_out("z_out", 32'h0002);
        chk_rd("z_mask", 3'd3, 32'd0);
        chk_rd("z_count", 3'd7, 32'd0);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'h0001_0000);
        chk_rd("z_count_hi", 3'd7, 32'd0);
        bus_if.address = 3'd0; bus_if.writedata = 32'h0000_FFFF;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        chk_out("z_nowrite", 32'h0002);

        // W1C of DONE on the expiry edge loses
        wr(3'd3, 32'h0000_0010);
        chk_out("w1c_out", 32'h0012);
        idle(2);
        wr(3'd1, 32'h0000_0002);
        chk_rd("w1c_status", 3'd1, 32'h0000_0002);
        chk_out("w1c_out_end", 32'h0002);
        wr(3'd1, 32'h0000_0002);
        chk_rd("w1c_status_clr", 3'd1, 32'h0000_0000);

        // DATA write empties mask; count still expires and sets DONE
        wr(3'd2, 32'd10);
        wr(3'd3, 32'h0000_0008);
        wr(3'd0, 32'h0000_1234);
        chk_rd("dm_mask", 3'd3, 32'd0);
        chk_rd("dm_count", 3'd7, 32'd9);
        idle(9);
        chk_rd("dm_count_end", 3'd7, 32'd0);
        chk_rd("dm_status", 3'd1, 32'h0000_0002);
        chk_out("dm_out", 32'h1234);
        wr(3'd1, 32'h0000_0100);
        check("dm_irq", 32'(irq), 32'd1);

        // Asynchronous reset mid-pulse
        wr(3'd2, 32'd6);
        wr(3'd3, 32'h0000_0100);
        chk_out("ar_out_pre", 32'h1334);
        idle(1);
        #1 reset_n = 1'b0;
        #1;
        chk_out("ar_out", 32'h00A5);
        check("ar_irq", 32'(irq), 32'd0);
        chk_rd("ar_count", 3'd7, 32'd0);
        chk_rd("ar_len", 3'd2, 32'd1000);
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        chk_out("ar_out_post", 32'h00A5);
        chk_rd("ar_status_post", 3'd1, 32'd0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
